// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  // Address width for a register count; a single register still needs one bit.
  function automatic int addr_w(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: storage mux, write-to-read bypass and next-state busy lookup.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = 32,
  parameter int AW     = addr_w(NREGS),
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  input  logic [NREGS-1:0]      busy_next,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic [XLEN-1:0]       rd_data,
  output logic                  rd_busy
);

  logic [XLEN-1:0] sel_data_p0;
  logic            sel_busy_p0;

  // Stage p0: select data and busy for this cycle's address.
  always_comb begin
    sel_data_p0 = regs_flat[int'(rd_addr)*XLEN +: XLEN];
    if (BYPASS != 0 && wr_en && (wr_addr == rd_addr))
      sel_data_p0 = wr_data;
    if (rd_addr == '0)
      sel_data_p0 = '0;
    sel_busy_p0 = busy_next[rd_addr];
  end

  // Stage p1: output registers, held while the port is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else if (rd_en) begin
      rd_data <= sel_data_p0;
      rd_busy <= sel_busy_p0;
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-read-port register file with a per-register pending-write scoreboard for RAW detection.
module regfile_mp_scoreboard
  import regfile_pkg::*;
#(
  parameter  int XLEN      = XLEN_DEFAULT,
  parameter  int NREGS     = 32,
  parameter  int NREAD     = 2,
  parameter  int BYPASS    = 1,
  parameter  int INIT_MODE = INIT_INDEX,
  localparam int AW        = addr_w(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  busy_set_en,
  input  logic [AW-1:0]         busy_set_addr
);

  logic [XLEN-1:0]       regs [NREGS];
  logic [NREGS*XLEN-1:0] regs_flat;
  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      busy_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (INIT_MODE == INIT_INDEX) ? XLEN'(i) : '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Set after clear: a newly issued producer outranks a retiring one.
  always_comb begin
    busy_next = busy;
    if (wr_en)
      busy_next[wr_addr] = 1'b0;
    if (busy_set_en)
      busy_next[busy_set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_next;
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*XLEN +: XLEN] = regs[g];
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    regfile_read_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_port (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en[p]),
      .rd_addr   (rd_addr[p*AW +: AW]),
      .regs_flat (regs_flat),
      .busy_next (busy_next),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_data   (rd_data[p*XLEN +: XLEN]),
      .rd_busy   (rd_busy[p])
    );
  end

endmodule
